// File: rtl/mac_seq_controller.sv
// Purpose : Moore sequencer for a multiply-accumulate datapath (INIT, then MULT/ADD/WB/CHECK per iteration, then DONE).
// Latency : done pulses 2+N*(MULT_LAT+3) cycles after the start edge for N>=1, 1 cycle after for N=0.
// Backpressure: none; start is sampled only while idle. Optional abort port enabled by defining MAC_ABORT_EN.
module mac_seq_controller #(
    parameter int CNT_W    = 4,
    parameter int MULT_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] iter_count,
`ifdef MAC_ABORT_EN
    input  logic             abort,
`endif
    output logic             load_a,
    output logic             acc_clr,
    output logic             mult_en,
    output logic             acc_en,
    output logic             wb_en,
    output logic             load_sel,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter_idx
);

    localparam int WAIT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MULT_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_MULT,
        S_ADD,
        S_WB,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  limit;
    logic [CNT_W-1:0]  limit_nxt;
    logic [CNT_W-1:0]  idx_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;

    // State and counter registers; reset clears everything so outputs drop immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            limit    <= '0;
            iter_idx <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            limit    <= limit_nxt;
            iter_idx <= idx_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next-state and counter update; the index is only touched on entry to INIT and in CHECK.
    always_comb begin
        state_nxt = state;
        limit_nxt = limit;
        idx_nxt   = iter_idx;
        wait_nxt  = wait_cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (iter_count != '0) begin
                        state_nxt = S_INIT;
                        limit_nxt = iter_count;
                        idx_nxt   = '0;
                        wait_nxt  = '0;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_INIT: begin
                state_nxt = S_MULT;
            end
            S_MULT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_ADD;
                    wait_nxt  = '0;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            S_ADD: begin
                state_nxt = S_WB;
            end
            S_WB: begin
                state_nxt = S_CHECK;
            end
            S_CHECK: begin
                // limit is never 0 here, so limit-1 cannot underflow; the index stops at
                // limit-1 and therefore never wraps even for the all-ones count.
                if (iter_idx == (limit - CNT_W'(1))) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_MULT;
                    idx_nxt   = iter_idx + CNT_W'(1);
                    wait_nxt  = '0;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
`ifdef MAC_ABORT_EN
        // Abort overrides every other transition in busy states; the index is left as-is.
        if (abort && (state != S_IDLE) && (state != S_DONE)) begin
            state_nxt = S_IDLE;
            limit_nxt = limit;
            idx_nxt   = iter_idx;
            wait_nxt  = wait_cnt;
        end
`endif
    end

    // Moore output decode from the registered state only.
    always_comb begin
        load_a   = 1'b0;
        acc_clr  = 1'b0;
        mult_en  = 1'b0;
        acc_en   = 1'b0;
        wb_en    = 1'b0;
        load_sel = 1'b0;
        busy     = (state != S_IDLE) && (state != S_DONE);
        done     = 1'b0;
        case (state)
            S_INIT: begin
                load_a  = 1'b1;
                acc_clr = 1'b1;
            end
            S_MULT:  mult_en = 1'b1;
            S_ADD:   acc_en  = 1'b1;
            S_WB: begin
                wb_en    = 1'b1;
                load_sel = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mac_seq_controller.sv
module tb_mac_seq_controller;

    localparam int CW = 4;
    localparam int ML [2] = '{1, 3};

    logic          clk;
    logic          rst;
    logic          st  [2];
    logic [CW-1:0] cnt [2];
    logic          ab  [2];
    logic [7:0]    fl  [2];   // {load_a, acc_clr, mult_en, acc_en, wb_en, load_sel, busy, done}
    logic [CW-1:0] ix  [2];

    int checks = 0;
    int errors = 0;

    mac_seq_controller #(.CNT_W(CW), .MULT_LAT(1)) dut_l1 (
        .clk(clk), .rst(rst), .start(st[0]), .iter_count(cnt[0]),
`ifdef MAC_ABORT_EN
        .abort(ab[0]),
`endif
        .load_a(fl[0][7]), .acc_clr(fl[0][6]), .mult_en(fl[0][5]), .acc_en(fl[0][4]),
        .wb_en(fl[0][3]), .load_sel(fl[0][2]), .busy(fl[0][1]), .done(fl[0][0]),
        .iter_idx(ix[0])
    );

    mac_seq_controller #(.CNT_W(CW), .MULT_LAT(3)) dut_l3 (
        .clk(clk), .rst(rst), .start(st[1]), .iter_count(cnt[1]),
`ifdef MAC_ABORT_EN
        .abort(ab[1]),
`endif
        .load_a(fl[1][7]), .acc_clr(fl[1][6]), .mult_en(fl[1][5]), .acc_en(fl[1][4]),
        .wb_en(fl[1][3]), .load_sel(fl[1][2]), .busy(fl[1][1]), .done(fl[1][0]),
        .iter_idx(ix[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: a sequence is just "cycles since the start edge"; outputs follow from arithmetic on that.
    bit m_act  [2] = '{0, 0};
    int m_k    [2] = '{0, 0};
    int m_dk   [2] = '{0, 0};
    int m_n    [2] = '{0, 0};
    int m_hold [2] = '{0, 0};

    function automatic logic [7:0] exp_flags(input int d);
        int p;
        int r;
        logic [7:0] f;
        if (!m_act[d]) return 8'h00;
        if (m_k[d] == m_dk[d]) return 8'b0000_0001;
        if (m_k[d] == 1) return 8'b1100_0010;
        p = m_k[d] - 2;
        r = p % (ML[d] + 3);
        f = 8'b0000_0010;
        if (r < ML[d])           f = f | 8'b0010_0000;
        else if (r == ML[d])     f = f | 8'b0001_0000;
        else if (r == ML[d] + 1) f = f | 8'b0000_1100;
        return f;
    endfunction

    function automatic int exp_idx(input int d);
        if (!m_act[d]) return m_hold[d];
        if (m_k[d] == m_dk[d]) return (m_n[d] == 0) ? m_hold[d] : m_n[d] - 1;
        if (m_k[d] == 1) return 0;
        return (m_k[d] - 2) / (ML[d] + 3);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                m_act[d]  = 1'b0;
                m_k[d]    = 0;
                m_hold[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_act[d]) begin
                    if (m_k[d] == m_dk[d]) begin
                        m_hold[d] = exp_idx(d);
                        m_act[d]  = 1'b0;
`ifdef MAC_ABORT_EN
                    end else if (ab[d]) begin
                        m_hold[d] = exp_idx(d);
                        m_act[d]  = 1'b0;
`endif
                    end else begin
                        m_k[d] = m_k[d] + 1;
                    end
                end else if (st[d]) begin
                    m_act[d] = 1'b1;
                    m_k[d]   = 1;
                    m_n[d]   = int'(cnt[d]);
                    m_dk[d]  = (m_n[d] == 0) ? 1 : 2 + m_n[d] * (ML[d] + 3);
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model, sampled after the edge.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (fl[d] !== exp_flags(d) || ix[d] !== CW'(exp_idx(d))) begin
                errors++;
                $display("FAIL cycle_cmp dut%0d t=%0t: outputs=%b idx=%0d, expected outputs=%b idx=%0d",
                         d, $time, fl[d], ix[d], exp_flags(d), exp_idx(d));
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    int r_la, r_mult, r_acc, r_wb, r_done;
    int n_la, n_mult, n_wb, n_busy, n_done, idx_done;

    // Starts a sequence on instance d from a negedge, then observes cycles 1..max_c.
    task automatic run(input int d, input int n, input int alt_c, input int ab_c, input int max_c);
        r_la = -1; r_mult = -1; r_acc = -1; r_wb = -1; r_done = -1;
        n_la = 0; n_mult = 0; n_wb = 0; n_busy = 0; n_done = 0; idx_done = -1;
        st[d]  = 1'b1;
        cnt[d] = CW'(n);
        for (int c = 1; c <= max_c; c++) begin
            @(negedge clk);
            if (fl[d][7]) begin n_la++;   if (r_la < 0)   r_la = c;   end
            if (fl[d][5]) begin n_mult++; if (r_mult < 0) r_mult = c; end
            if (fl[d][4] && r_acc < 0) r_acc = c;
            if (fl[d][3]) begin n_wb++;   if (r_wb < 0)   r_wb = c;   end
            if (fl[d][1]) n_busy++;
            if (fl[d][0]) begin
                n_done++;
                if (r_done < 0) begin r_done = c; idx_done = int'(ix[d]); end
            end
            st[d] = (c == alt_c);
            if (c == 1 || c == alt_c) cnt[d] = CW'(n + 5);
            ab[d] = (c == ab_c);
        end
        st[d] = 1'b0;
        ab[d] = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0; cnt[d] = '0; ab[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("reset_outputs_l1", int'(fl[0]), 0);
        chk("reset_idx_l1", int'(ix[0]), 0);
        rst = 1'b1;
        @(negedge clk);

        // Single iteration, MULT_LAT=1
        run(0, 1, 0, 0, 10);
        chk("n1_load_a_cycle", r_la, 1);
        chk("n1_mult_cycle", r_mult, 2);
        chk("n1_acc_cycle", r_acc, 3);
        chk("n1_wb_cycle", r_wb, 4);
        chk("n1_done_cycle", r_done, 6);

        // Three iterations
        run(0, 3, 0, 0, 18);
        chk("n3_wb_pulses", n_wb, 3);
        chk("n3_done_cycle", r_done, 14);
        chk("n3_done_count", n_done, 1);
        chk("n3_busy_cycles", n_busy, 13);
        chk("n3_idx_at_done", idx_done, 2);

        // MULT_LAT=3, two iterations
        run(1, 2, 0, 0, 18);
        chk("l3_mult_cycles", n_mult, 6);
        chk("l3_done_cycle", r_done, 14);

        // Zero-length request
        run(0, 0, 0, 0, 5);
        chk("n0_done_cycle", r_done, 1);
        chk("n0_load_a", n_la, 0);
        chk("n0_mult", n_mult, 0);
        chk("n0_wb", n_wb, 0);
        chk("n0_idx_held", idx_done, 2);

        // start (and a new count) while busy is ignored
        run(0, 2, 4, 0, 14);
        chk("busy_start_done_cycle", r_done, 10);
        chk("busy_start_done_count", n_done, 1);
        chk("busy_start_wb", n_wb, 2);

        // Full count: no wrap of the index
        run(0, 15, 0, 0, 66);
        chk("n15_done_cycle", r_done, 62);
        chk("n15_wb", n_wb, 15);
        chk("n15_idx_at_done", idx_done, 14);

        // Reset during MULT of the second iteration
        run(1, 3, 0, 0, 9);
        chk("rst_pre_mult", int'(fl[1][5]), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_outputs", int'(fl[1]), 0);
        chk("rst_async_idx", int'(ix[1]), 0);
        @(negedge clk);
        chk("rst_held_done", int'(fl[1][0]), 0);
        rst = 1'b1;
        run(1, 1, 0, 0, 10);
        chk("post_rst_done_cycle", r_done, 8);

`ifdef MAC_ABORT_EN
        // Abort while in ADD
        run(0, 2, 0, 3, 12);
        chk("abort_busy_cycles", n_busy, 3);
        chk("abort_done_count", n_done, 0);
        chk("abort_idx", int'(ix[0]), 0);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
